// File: rtl/prng_checker_if.sv
// Symbol-stream and status bundle between a PRNG symbol source and prng_checker.
// The master drives symbols and the clear; the slave (checker) drives status.
interface prng_checker_if #(
   parameter int ERR_W = 8
) ();
   logic             valid_in;
   logic [1:0]       data_in;
   logic             err_clr;
   logic             locked;
   logic             err;
   logic [ERR_W-1:0] err_count;

   modport master (
      output valid_in, data_in, err_clr,
      input  locked, err, err_count
   );

   modport slave (
      input  valid_in, data_in, err_clr,
      output locked, err, err_count
   );
endinterface

// File: rtl/prng_checker.sv
// Receive-side checker for the 2-bit symbol stream of the 3-bit LFSR generator.
// Hunts for lock from received history, then free-runs its own model and counts mismatches.
module prng_checker #(
   parameter int LOCK_N = 4,
   parameter int LOSS_N = 3,
   parameter int ERR_W  = 8
) (
   input logic           clk,
   input logic           rst,
   prng_checker_if.slave bus
);
   localparam int GW = $clog2(LOCK_N + 1);
   localparam int BW = $clog2(LOSS_N + 1);
   localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_N);
   localparam logic [BW-1:0]    BAD_MAX  = BW'(LOSS_N);
   localparam logic [ERR_W-1:0] CNT_MAX  = '1;

   typedef enum logic {
      S_HUNT,
      S_LOCKED
   } state_t;

   state_t           state, state_next;
   logic [1:0]       h0, h1, pred;
   logic [1:0]       hcnt;
   logic [GW-1:0]    good_run, good_next;
   logic [BW-1:0]    bad_run, bad_next;
   logic             locked_q, err_q;
   logic [ERR_W-1:0] err_cnt_q;
   logic             hunt_match, cnt_inc;

   // Next symbol of the generator, reconstructed from the last two symbols.
   assign pred = {h0[0], h1[1] ^ h0[0]};

   // An all-zero history predicts 00 forever, so a stuck-zero line must not count as a match.
   assign hunt_match = (bus.data_in == pred) &&
                       !(h1 == 2'b00 && h0 == 2'b00 && bus.data_in == 2'b00);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      state_next = state;
      good_next  = good_run;
      bad_next   = bad_run;
      cnt_inc    = 1'b0;
      if (bus.valid_in) begin
         case (state)
            S_HUNT: begin
               if (hcnt == 2'd2) begin
                  if (hunt_match) begin
                     good_next = good_run + 1'b1;
                     if (good_next == GOOD_MAX) begin
                        state_next = S_LOCKED;
                        bad_next   = '0;
                     end
                  end else begin
                     good_next = '0;
                  end
               end
            end
            S_LOCKED: begin
               if (bus.data_in != pred) begin
                  cnt_inc  = 1'b1;
                  bad_next = bad_run + 1'b1;
                  if (bad_next == BAD_MAX) begin
                     state_next = S_HUNT;
                     good_next  = '0;
                  end
               end else begin
                  bad_next = '0;
               end
            end
            default: state_next = S_HUNT;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= S_HUNT;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h0        <= 2'b00;
         h1        <= 2'b00;
         hcnt      <= 2'd0;
         good_run  <= '0;
         bad_run   <= '0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         good_run <= good_next;
         bad_run  <= bad_next;
         locked_q <= (state_next == S_LOCKED);
         err_q    <= cnt_inc;
         if (bus.valid_in) begin
            h1 <= h0;
            // While locked the model free-runs: received data never enters history.
            h0 <= (state == S_LOCKED) ? pred : bus.data_in;
            if (hcnt != 2'd2) hcnt <= hcnt + 2'd1;
         end
         if (bus.err_clr)
            err_cnt_q <= '0;
         else if (cnt_inc && err_cnt_q != CNT_MAX)
            err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err       = err_q;
   assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_prng_checker.sv
// Self-checking bench for prng_checker: two instances (ERR_W=8 and ERR_W=2) share one
// stimulus stream and are compared every cycle against a behavioural model of the checker.
module tb_prng_checker;
   localparam int LOCK_N = 4;
   localparam int LOSS_N = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;

   prng_checker_if #(.ERR_W(8)) bus8 ();
   prng_checker_if #(.ERR_W(2)) bus2 ();

   prng_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .ERR_W(8)) dut8 (
      .clk(clk), .rst(rst), .bus(bus8)
   );
   prng_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   always #5 clk = ~clk;

   int    checks   = 0;
   int    failures = 0;
   string phase    = "init";

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, tag, got, exp, $time);
      end
   endtask

   // Reference generator: one period of the 3-bit LFSR symbol stream.
   int seq [7] = '{1, 3, 3, 2, 1, 2, 0};
   int gi = 0;

   function automatic logic [1:0] next_sym();
      logic [1:0] s;
      s  = 2'(seq[gi]);
      gi = (gi + 1) % 7;
      return s;
   endfunction

   // Behavioural checker model.
   int m_h0, m_h1, m_hcnt, m_good, m_bad, m_cnt8, m_cnt2;
   bit m_lock, m_err;

   function automatic void model_reset();
      m_h0 = 0; m_h1 = 0; m_hcnt = 0; m_good = 0; m_bad = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_lock = 0; m_err = 0;
   endfunction

   function automatic void model_step(bit v, int d, bit clr);
      int  p;
      bit  ok;
      m_err = 0;
      if (v) begin
         // next generator symbol is {l0, l2^l0}; l2 is bit 1 of the older symbol
         p = ((m_h0 % 2) * 2) + (((m_h1 / 2) % 2) ^ (m_h0 % 2));
         if (!m_lock) begin
            if (m_hcnt == 2) begin
               ok = (d == p) && !(m_h0 == 0 && m_h1 == 0 && d == 0);
               if (ok) begin
                  m_good++;
                  if (m_good == LOCK_N) begin
                     m_lock = 1;
                     m_bad  = 0;
                  end
               end else begin
                  m_good = 0;
               end
            end
            m_h1 = m_h0;
            m_h0 = d;
            if (m_hcnt < 2) m_hcnt++;
         end else begin
            if (d != p) begin
               m_err  = 1;
               m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
               m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
               m_bad++;
               if (m_bad == LOSS_N) begin
                  m_lock = 0;
                  m_good = 0;
               end
            end else begin
               m_bad = 0;
            end
            m_h1 = m_h0;
            m_h0 = p;
         end
      end
      if (clr) begin
         m_cnt8 = 0;
         m_cnt2 = 0;
      end
   endfunction

   task automatic step(input bit v, input logic [1:0] d, input bit clr, input bit r);
      rst           = r;
      bus8.valid_in = v;  bus2.valid_in = v;
      bus8.data_in  = d;  bus2.data_in  = d;
      bus8.err_clr  = clr; bus2.err_clr = clr;
      @(posedge clk);
      #1;
      if (r) model_reset();
      else   model_step(v, int'(d), clr);
      check("locked8", {31'd0, bus8.locked}, {31'd0, m_lock});
      check("err8",    {31'd0, bus8.err},    {31'd0, m_err});
      check("cnt8",    {24'd0, bus8.err_count}, m_cnt8);
      check("locked2", {31'd0, bus2.locked}, {31'd0, m_lock});
      check("err2",    {31'd0, bus2.err},    {31'd0, m_err});
      check("cnt2",    {30'd0, bus2.err_count}, m_cnt2);
   endtask

   task automatic do_reset();
      step(1'b0, 2'b00, 1'b0, 1'b1);
      rst = 1'b0;
      gi  = 0;
   endtask

   task automatic send_good(input int n);
      for (int i = 0; i < n; i++) step(1'b1, next_sym(), 1'b0, 1'b0);
   endtask

   task automatic send_bad();
      logic [1:0] s, x;
      s = next_sym();
      x = 2'($urandom_range(1, 3));
      step(1'b1, s ^ x, 1'b0, 1'b0);
   endtask

   initial begin
      bus8.valid_in = 1'b0; bus2.valid_in = 1'b0;
      bus8.data_in  = 2'b00; bus2.data_in = 2'b00;
      bus8.err_clr  = 1'b0; bus2.err_clr  = 1'b0;
      model_reset();

      phase = "reset";
      do_reset();
      check("rst_locked", {31'd0, bus8.locked}, 32'd0);
      check("rst_cnt",    {24'd0, bus8.err_count}, 32'd0);

      phase = "lock";
      send_good(5);
      check("lock_before6", {31'd0, bus8.locked}, 32'd0);
      send_good(1);
      check("lock_after6", {31'd0, bus8.locked}, 32'd1);
      send_good(24);
      check("clean_cnt", {24'd0, bus8.err_count}, 32'd0);

      phase = "single_err";
      while (seq[gi] != 3) send_good(1);
      void'(next_sym());
      step(1'b1, 2'b00, 1'b0, 1'b0);
      check("single_pulse", {31'd0, bus8.err}, 32'd1);
      check("single_cnt",   {24'd0, bus8.err_count}, 32'd1);
      check("single_lock",  {31'd0, bus8.locked}, 32'd1);
      send_good(10);
      check("single_after", {24'd0, bus8.err_count}, 32'd1);

      phase = "loss";
      step(1'b0, 2'b00, 1'b1, 1'b0);
      send_bad(); send_bad();
      check("loss_still_locked", {31'd0, bus8.locked}, 32'd1);
      send_bad();
      check("loss_cnt",   {24'd0, bus8.err_count}, 32'd3);
      check("loss_drop",  {31'd0, bus8.locked}, 32'd0);
      check("loss_pulse", {31'd0, bus8.err}, 32'd1);
      send_good(3);
      check("relock_before4", {31'd0, bus8.locked}, 32'd0);
      send_good(1);
      check("relock_after4", {31'd0, bus8.locked}, 32'd1);

      phase = "stuck_zero";
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 2'b00, 1'b0, 1'b0);
      check("zero_locked", {31'd0, bus8.locked}, 32'd0);
      check("zero_err",    {31'd0, bus8.err}, 32'd0);

      phase = "gaps";
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 2'($urandom), 1'b0, 1'b0);
         step(1'b0, 2'($urandom), 1'b0, 1'b0);
         if (i == 6) check("gap_before6", {31'd0, bus8.locked}, 32'd0);
         send_good(1);
      end
      check("gap_lock", {31'd0, bus8.locked}, 32'd1);
      step(1'b0, 2'(seq[gi] ^ 1), 1'b0, 1'b0);
      check("gap_inject_err", {31'd0, bus8.err}, 32'd0);
      check("gap_inject_cnt", {24'd0, bus8.err_count}, 32'd0);

      phase = "saturate";
      send_good(3);
      for (int i = 0; i < 5; i++) begin
         send_bad();
         send_good(1);
      end
      check("sat_cnt2", {30'd0, bus2.err_count}, 32'd3);
      check("sat_cnt8", {24'd0, bus8.err_count}, 32'd5);
      check("sat_lock", {31'd0, bus2.locked}, 32'd1);
      begin
         logic [1:0] s;
         s = next_sym();
         step(1'b1, s ^ 2'b10, 1'b1, 1'b0);
      end
      check("clr_err",  {31'd0, bus2.err}, 32'd1);
      check("clr_cnt2", {30'd0, bus2.err_count}, 32'd0);
      check("clr_cnt8", {24'd0, bus8.err_count}, 32'd0);

      phase = "random";
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 199));
         if (r == 0) begin
            do_reset();
         end else if (r < 40) begin
            step(1'b0, 2'($urandom), (r < 6), 1'b0);
         end else if (r < 52) begin
            send_bad();
         end else if (r < 56) begin
            step(1'b1, 2'($urandom), 1'b0, 1'b0);
         end else begin
            step(1'b1, next_sym(), (r > 196), 1'b0);
         end
      end

      phase = "mid_reset";
      do_reset();
      send_good(8);
      send_bad();
      check("pre_rst_lock", {31'd0, bus8.locked}, 32'd1);
      do_reset();
      check("mid_rst_locked", {31'd0, bus8.locked}, 32'd0);
      check("mid_rst_err",    {31'd0, bus8.err}, 32'd0);
      check("mid_rst_cnt",    {24'd0, bus8.err_count}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
